// File: rtl/debounce_pulse.sv
// -----------------------------------------------------------------------------
// debounce_pulse
//
// Conditions a raw push-button / switch input for use inside the clk domain.
// The raw signal is brought through a two-flop synchroniser, then filtered by
// a four-state machine with a stability counter.
//
// The output level changes only when the synchronised input has disagreed
// with it for STABLE_CYCLES+1 consecutive samples: the first differing sample
// followed by STABLE_CYCLES confirming ones. Any single agreeing sample
// restarts the qualification window.
//
// Parameters
//   STABLE_CYCLES : confirming samples required after the first differing one
//                   (>= 1)
//   CNT_W         : stability counter width; 2**CNT_W must exceed
//                   STABLE_CYCLES-1
//   PCNT_W        : press counter width
//
// Ports
//   clk         in   system clock, rising edge
//   clr         in   asynchronous active-high reset
//   btn_in      in   raw button, asynchronous to clk, may bounce
//   btn_level   out  debounced level (registered)
//   rise_pulse  out  one-cycle pulse when btn_level goes 0->1
//   fall_pulse  out  one-cycle pulse when btn_level goes 1->0
//   press_count out  accepted rising edges, modulo 2**PCNT_W
// -----------------------------------------------------------------------------
module debounce_pulse #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 20,
   parameter int PCNT_W        = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              btn_in,
   output logic              btn_level,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic [PCNT_W-1:0] press_count
);

   localparam logic [1:0] IDLE_LOW  = 2'd0;
   localparam logic [1:0] WAIT_HIGH = 2'd1;
   localparam logic [1:0] IDLE_HIGH = 2'd2;
   localparam logic [1:0] WAIT_LOW  = 2'd3;

   // Counter value at which the final confirming sample arrives.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic              r_sync0;
   logic              r_sync1;
   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_level;
   logic              r_rise;
   logic              r_fall;
   logic [PCNT_W-1:0] r_pcnt;

   logic [1:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_level_nxt;
   logic              w_rise_nxt;
   logic              w_fall_nxt;
   logic [PCNT_W-1:0] w_pcnt_nxt;

   // Two-flop synchroniser. r_sync0 may go metastable. Only r_sync1 is used
   // by the filter.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= btn_in;
         r_sync1 <= r_sync0;
      end
   end

   // Filter FSM next-state logic. The pulses default low, so each one lasts
   // exactly the single cycle in which the level flips.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      w_pcnt_nxt  = r_pcnt;
      case (r_state)
         IDLE_LOW: begin
            if (r_sync1) begin
               w_state_nxt = WAIT_HIGH;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!r_sync1) begin
               // Disagreement: abandon the window and restart counting later.
               w_state_nxt = IDLE_LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_HIGH;
               w_level_nxt = 1'b1;
               w_rise_nxt  = 1'b1;
               w_pcnt_nxt  = r_pcnt + PCNT_W'(1);   // wraps silently
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         IDLE_HIGH: begin
            if (!r_sync1) begin
               w_state_nxt = WAIT_LOW;
               w_cnt_nxt   = '0;
            end
         end
         WAIT_LOW: begin
            if (r_sync1) begin
               w_state_nxt = IDLE_HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_LOW;
               w_level_nxt = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= IDLE_LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_pcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
         r_pcnt  <= w_pcnt_nxt;
      end
   end

   assign btn_level   = r_level;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign press_count = r_pcnt;

endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Input-conditioning stage that sits directly upstream of the team's clearable D flip-flop and drives its D input.
- Takes a raw, asynchronous, bouncy push-button or switch signal and synchronises it to clk.
- Filters the signal with a stability counter and state machine.
- Outputs a clean debounced level, one-cycle rise/fall pulses, and a wrapping press counter.

Parameters:
- STABLE_CYCLES, 4: consecutive agreeing synchronised samples required, after the first differing sample, before the output level changes. Must be ≥ 1. Use 4 for simulation and about 1_000_000 on the board.
- CNT_W, 20: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES-1.
- PCNT_W, 8: width of press_count.

Ports:
- clk  input  1  system clock, rising-edge active.
- clr  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw button/switch; asynchronous to clk and may bounce.
- btn_level  output  1  debounced level; feeds D of the downstream flip-flop.
- rise_pulse  output  1  high for exactly one cycle when btn_level goes 0→1.
- fall_pulse  output  1  high for exactly one cycle when btn_level goes 1→0.
- press_count  output  PCNT_W  number of accepted rising edges, modulo 2^PCNT_W.

Behaviour:
- **Reset.** Synchronous elements are clock: single clock (clk). Reset: asynchronous, active-high (clr).
  - While clr=1, all of the following are 0: sync0, sync1, cnt, btn_level, rise_pulse, fall_pulse, press_count. State = IDLE_LOW.
  - Reset takes effect immediately, with no clock needed.
- **Synchroniser.** Two flops, btn_in→sync0→sync1. Only sync1 feeds the FSM.
- **FSM states:** IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. All outputs are registered.
- **IDLE_LOW:**
  - sync1=1 → WAIT_HIGH, cnt←0.
  - Otherwise stay.
- **WAIT_HIGH:**
  - sync1=0 → IDLE_LOW, cnt←0, no output change.
  - sync1=1 and cnt==STABLE_CYCLES-1 → IDLE_HIGH; btn_level←1, rise_pulse←1, press_count←press_count+1.
  - Otherwise cnt←cnt+1.
- **IDLE_HIGH / WAIT_LOW:** mirror image of the above. The confirmed transition goes to IDLE_LOW with btn_level←0 and fall_pulse←1. press_count is unchanged on fall.
- **Pulses:** rise_pulse and fall_pulse default to 0 every cycle. They assert in the same cycle btn_level changes and are never both high.
- **Latency:** btn_in held stable from before clock edge k → btn_level changes after edge k+STABLE_CYCLES+2 (2 synchroniser edges + 1 detect edge + STABLE_CYCLES confirm edges).
- **Glitch rejection:** any sync1 excursion lasting ≤ STABLE_CYCLES cycles produces no output change and no pulse. The counter restarts from 0 on every disagreement.
- **Wrap:** press_count rolls over from 2^PCNT_W-1 to 0 with no flag.
- **Reset mid-window:** asserting clr during WAIT_* aborts the window. If btn_in is still high when clr releases, a full new window runs and a normal rise_pulse is produced.

Test Plan (STABLE_CYCLES=4, clk period 20 ns):
1. **Reset:** clr=1 for 3 cycles with btn_in=1 → all outputs 0 throughout. Release clr → btn_level=1 and rise_pulse=1 for one cycle, 6 edges after the first post-release edge; press_count=1.
2. **Clean press:** btn_in 0→1 held for 12 cycles, then 1→0 → rise_pulse at edge k+6 and fall_pulse 6 edges after the release. Each pulse lasts 1 cycle; press_count increments by 1 only.
3. **Bounce:** btn_in toggles 1,0,1,0,1 with 1–2 cycle widths, then stays 1 → exactly one rise_pulse, 6 edges after the final stable edge; no fall_pulse.
4. **Short glitch:** btn_in high for 3 cycles only → btn_level stays 0, no pulses, press_count unchanged.
5. **Reset mid-window:** clr asserted 2 cycles into WAIT_HIGH, released with btn_in=1 → outputs reset immediately, then one rise_pulse after a full window.
6. **Wrap:** 256 clean presses → press_count returns to 0x00 after the 256th press; 255 is observed immediately before it.
